third_pipe_ex: RTL and testbench

- Execute stage plus EX/MEM pipeline register, directly downstream of the ID/EX register.
- Consumes the ID/EX outputs (suffix 3): operand forwarding from MEM and WB, ALU operation, branch/jump resolution and an iterative 32-cycle multiplier.
- Results are registered into EX/MEM outputs (suffix 4).
- Drives PC redirect and a stall request back to IF/ID/ID-EX.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/seq_multiplier.sv | 78 +++++++
 rtl/third_pipe_ex.sv | 155 +++++++++++++++
 tb/tb_third_pipe_ex.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage.
// Contents: datapath word width, ALU operation codes carried in ALUOp3,
// and the state encoding of the iterative multiplier FSM.
package cpu_pkg;

    localparam int WORD = 32;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;
    localparam logic [3:0] ALU_MUL = 4'd11;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier producing the low WORD bits of a*b.
// Ports:
//   CLK, RST   clock and asynchronous active-high reset
//   start      request a new multiply; only honoured while idle
//   a, b       multiplicand / multiplier, captured on the start edge
//   done       one-cycle strobe during the final iteration
//   result     product, valid while done is high
//   fsm_state  current FSM state (IDLE / MUL_BUSY) for observation
//
// Handshake: start is sampled on a clock edge only while the FSM is IDLE;
// the operands are captured on that same edge. done is high for exactly one
// cycle (the last of MUL_CYCLES busy cycles) and result is valid only while
// done is high; the FSM is IDLE again after that edge.
module seq_multiplier
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [WORD-1:0]   a,
    input  logic [WORD-1:0]   b,
    output logic              done,
    output logic [WORD-1:0]   result,
    output logic              fsm_state
);

    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_t       state;
    logic [WORD-1:0]  mcand;
    logic [WORD-1:0]  mplier;
    logic [WORD-1:0]  acc;
    logic [CNT_W-1:0] count;
    logic [WORD-1:0]  acc_step;

    // Accumulator value after the current iteration; on the last iteration
    // this is the finished product, so it is offered as the result directly.
    assign acc_step  = mplier[0] ? (acc + mcand) : acc;
    assign done      = (state == MUL_BUSY) && (count == LAST);
    assign result    = acc_step;
    assign fsm_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/third_pipe_ex.sv
// Execute stage with the EX/MEM pipeline register.
// Ports:
//   CLK, RST                          clock, asynchronous active-high reset
//   *3 inputs                         ID/EX register outputs (operands, controls)
//   WB_RegWrite/WB_WriteReg_addr/WB_Data  write-back stage, used for forwarding
//   *4 outputs                        registered EX/MEM results and controls
//   PC_Redirect, Redirect_PC          combinational branch/jump redirect
//   Stall_Out                         combinational hold request to upstream
// A MUL holds the stage for MUL_CYCLES+1 cycles; all other ops take one.
module third_pipe_ex
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  ReadReg_addr13,
    input  logic [4:0]  ReadReg_addr23,
    input  logic [4:0]  WriteReg_addr3,
    input  logic [31:0] Imm3,
    input  logic [31:0] ReadData13,
    input  logic [31:0] ReadData23,
    input  logic [31:0] Next_PC3,
    input  logic        JtoPC3,
    input  logic        Branch3,
    input  logic        RegWrite3,
    input  logic        ALUSrc3,
    input  logic        MemWrite3,
    input  logic        MemRead3,
    input  logic        MemtoReg3,
    input  logic [3:0]  ALUOp3,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteReg_addr,
    input  logic [31:0] WB_Data,
    output logic [31:0] ALUResult4,
    output logic [31:0] WriteData4,
    output logic [4:0]  WriteReg_addr4,
    output logic        RegWrite4,
    output logic        MemWrite4,
    output logic        MemRead4,
    output logic        MemtoReg4,
    output logic        PC_Redirect,
    output logic [31:0] Redirect_PC,
    output logic        Stall_Out
);

    logic [WORD-1:0] fwd_a, fwd_b, alu_b, alu_res, mul_res;
    logic            mem_ok, wb_ok;
    logic            is_mul, mul_idle, mul_start, mul_done, mul_fsm_state;

    // A load result is not yet in ALUResult4, so MEM forwarding excludes it.
    assign mem_ok = RegWrite4 && !MemtoReg4 && (WriteReg_addr4 != 5'd0);
    assign wb_ok  = WB_RegWrite && (WB_WriteReg_addr != 5'd0);

    always_comb begin
        fwd_a = ReadData13;
        if (mem_ok && (WriteReg_addr4 == ReadReg_addr13))
            fwd_a = ALUResult4;
        else if (wb_ok && (WB_WriteReg_addr == ReadReg_addr13))
            fwd_a = WB_Data;
    end

    always_comb begin
        fwd_b = ReadData23;
        if (mem_ok && (WriteReg_addr4 == ReadReg_addr23))
            fwd_b = ALUResult4;
        else if (wb_ok && (WB_WriteReg_addr == ReadReg_addr23))
            fwd_b = WB_Data;
    end

    assign alu_b = ALUSrc3 ? Imm3 : fwd_b;

    always_comb begin
        alu_res = '0;
        case (ALUOp3)
            ALU_ADD: alu_res = fwd_a + alu_b;
            ALU_SUB: alu_res = fwd_a - alu_b;
            ALU_AND: alu_res = fwd_a & alu_b;
            ALU_OR:  alu_res = fwd_a | alu_b;
            ALU_XOR: alu_res = fwd_a ^ alu_b;
            ALU_NOR: alu_res = ~(fwd_a | alu_b);
            ALU_SLT: alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            ALU_SLL: alu_res = fwd_a << alu_b[4:0];
            ALU_SRL: alu_res = fwd_a >> alu_b[4:0];
            ALU_SRA: alu_res = $unsigned($signed(fwd_a) >>> alu_b[4:0]);
            ALU_LUI: alu_res = {alu_b[15:0], 16'h0000};
            default: alu_res = '0;   // MUL result comes from the multiplier
        endcase
    end

    assign is_mul    = (ALUOp3 == ALU_MUL);
    assign mul_idle  = (mul_fsm_state == IDLE);
    assign mul_start = mul_idle && is_mul;

    seq_multiplier #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .CLK       (CLK),
        .RST       (RST),
        .start     (mul_start),
        .a         (fwd_a),
        .b         (alu_b),
        .done      (mul_done),
        .result    (mul_res),
        .fsm_state (mul_fsm_state)
    );

    // Stall while starting or iterating; released on the final iteration so
    // the product commits on the same edge the FSM returns to IDLE.
    assign Stall_Out = mul_start || (!mul_idle && !mul_done);

    always_comb begin
        PC_Redirect = 1'b0;
        Redirect_PC = '0;
        if (!Stall_Out) begin
            if (JtoPC3) begin
                PC_Redirect = 1'b1;
                Redirect_PC = {Next_PC3[31:28], Imm3[25:0], 2'b00};
            end else if (Branch3 && (fwd_a == fwd_b)) begin
                PC_Redirect = 1'b1;
                Redirect_PC = Next_PC3 + (Imm3 << 2);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALUResult4     <= '0;
            WriteData4     <= '0;
            WriteReg_addr4 <= '0;
            RegWrite4      <= 1'b0;
            MemWrite4      <= 1'b0;
            MemRead4       <= 1'b0;
            MemtoReg4      <= 1'b0;
        end else if (Stall_Out) begin
            // Bubble: nothing downstream may act on a half-finished MUL.
            ALUResult4     <= '0;
            WriteData4     <= '0;
            WriteReg_addr4 <= '0;
            RegWrite4      <= 1'b0;
            MemWrite4      <= 1'b0;
            MemRead4       <= 1'b0;
            MemtoReg4      <= 1'b0;
        end else begin
            ALUResult4     <= mul_done ? mul_res : alu_res;
            WriteData4     <= fwd_b;
            WriteReg_addr4 <= WriteReg_addr3;
            RegWrite4      <= RegWrite3;
            MemWrite4      <= MemWrite3;
            MemRead4       <= MemRead3;
            MemtoReg4      <= MemtoReg3;
        end
    end

endmodule

// File: tb/tb_third_pipe_ex.sv
module tb_third_pipe_ex;
    import cpu_pkg::*;

    logic        CLK, RST;
    logic [4:0]  ReadReg_addr13, ReadReg_addr23, WriteReg_addr3;
    logic [31:0] Imm3, ReadData13, ReadData23, Next_PC3;
    logic        JtoPC3, Branch3, RegWrite3, ALUSrc3, MemWrite3, MemRead3, MemtoReg3;
    logic [3:0]  ALUOp3;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg_addr;
    logic [31:0] WB_Data;
    logic [31:0] ALUResult4, WriteData4;
    logic [4:0]  WriteReg_addr4;
    logic        RegWrite4, MemWrite4, MemRead4, MemtoReg4;
    logic        PC_Redirect;
    logic [31:0] Redirect_PC;
    logic        Stall_Out;

    third_pipe_ex #(.MUL_CYCLES(32)) dut (
        .CLK(CLK), .RST(RST),
        .ReadReg_addr13(ReadReg_addr13), .ReadReg_addr23(ReadReg_addr23),
        .WriteReg_addr3(WriteReg_addr3), .Imm3(Imm3),
        .ReadData13(ReadData13), .ReadData23(ReadData23), .Next_PC3(Next_PC3),
        .JtoPC3(JtoPC3), .Branch3(Branch3), .RegWrite3(RegWrite3),
        .ALUSrc3(ALUSrc3), .MemWrite3(MemWrite3), .MemRead3(MemRead3),
        .MemtoReg3(MemtoReg3), .ALUOp3(ALUOp3),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg_addr(WB_WriteReg_addr),
        .WB_Data(WB_Data),
        .ALUResult4(ALUResult4), .WriteData4(WriteData4),
        .WriteReg_addr4(WriteReg_addr4), .RegWrite4(RegWrite4),
        .MemWrite4(MemWrite4), .MemRead4(MemRead4), .MemtoReg4(MemtoReg4),
        .PC_Redirect(PC_Redirect), .Redirect_PC(Redirect_PC),
        .Stall_Out(Stall_Out)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected EX/MEM contents plus a multiply countdown: a MUL is seen as
    // "product a*b, delivered after 32 stalled cycles".
    logic [31:0] m_alu, m_wd;
    logic [4:0]  m_wa;
    logic        m_rw, m_mw, m_mr, m_m2r;
    int          mul_left;
    logic [31:0] mul_prod;
    int          stall_seen;

    task automatic model_reset();
        m_alu = '0; m_wd = '0; m_wa = '0;
        m_rw = 0; m_mw = 0; m_mr = 0; m_m2r = 0;
        mul_left = 0; mul_prod = '0;
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] regval);
        if (m_rw && !m_m2r && m_wa != 0 && m_wa == src) return m_alu;
        if (WB_RegWrite && WB_WriteReg_addr != 0 && WB_WriteReg_addr == src) return WB_Data;
        return regval;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a | b);
            4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  r = a << sh;
            4'd8:  r = a >> sh;
            4'd9:  begin
                       r = a >> sh;
                       if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                   end
            4'd10: r = b * 32'd65536;
            4'd11: r = a * b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One pipeline cycle: check combinational outputs, clock, update model,
    // check registered outputs. Entered and left at posedge+1.
    task automatic run_cycle();
        logic [31:0] fa, fb, bop, tgt;
        logic        stall_e, redir_e;
        fa  = ref_fwd(ReadReg_addr13, ReadData13);
        fb  = ref_fwd(ReadReg_addr23, ReadData23);
        bop = ALUSrc3 ? Imm3 : fb;
        if (mul_left == 0) stall_e = (ALUOp3 == 4'd11);
        else               stall_e = (mul_left > 1);
        redir_e = 0;
        tgt = '0;
        if (!stall_e && JtoPC3) begin
            redir_e = 1;
            tgt = (Next_PC3 & 32'hF000_0000) | ((Imm3 & 32'h03FF_FFFF) * 4);
        end else if (!stall_e && Branch3 && fa == fb) begin
            redir_e = 1;
            tgt = Next_PC3 + Imm3 * 4;
        end
        #1;
        check_eq("stall", Stall_Out, stall_e);
        check_eq("redirect", PC_Redirect, redir_e);
        check_eq("redirect_pc", Redirect_PC, tgt);
        if (Stall_Out) stall_seen++;
        @(posedge CLK);
        #1;
        if (stall_e) begin
            if (mul_left == 0) begin
                mul_prod = ref_alu(4'd11, fa, bop);
                mul_left = 32;
            end else begin
                mul_left--;
            end
            m_alu = '0; m_wd = '0; m_wa = '0;
            m_rw = 0; m_mw = 0; m_mr = 0; m_m2r = 0;
        end else begin
            m_alu = (mul_left == 1) ? mul_prod : ref_alu(ALUOp3, fa, bop);
            mul_left = 0;
            m_wd = fb; m_wa = WriteReg_addr3;
            m_rw = RegWrite3; m_mw = MemWrite3; m_mr = MemRead3; m_m2r = MemtoReg3;
        end
        check_eq("alu_result4", ALUResult4, m_alu);
        check_eq("write_data4", WriteData4, m_wd);
        check_eq("write_reg4", WriteReg_addr4, m_wa);
        check_eq("ctrl4", {RegWrite4, MemWrite4, MemRead4, MemtoReg4}, {m_rw, m_mw, m_mr, m_m2r});
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_nop();
        ReadReg_addr13 = 0; ReadReg_addr23 = 0; WriteReg_addr3 = 0;
        Imm3 = 0; ReadData13 = 0; ReadData23 = 0; Next_PC3 = 0;
        JtoPC3 = 0; Branch3 = 0; RegWrite3 = 0; ALUSrc3 = 0;
        MemWrite3 = 0; MemRead3 = 0; MemtoReg3 = 0; ALUOp3 = 4'd0;
        WB_RegWrite = 0; WB_WriteReg_addr = 0; WB_Data = 0;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] a,
                           input logic [4:0] rt, input logic [31:0] b, input logic [4:0] rd);
        set_nop();
        ALUOp3 = op; ReadReg_addr13 = rs; ReadData13 = a;
        ReadReg_addr23 = rt; ReadData23 = b; WriteReg_addr3 = rd;
        RegWrite3 = (rd != 0);
    endtask

    task automatic randomize_wb();
        WB_RegWrite      = 1'($urandom_range(0, 1));
        WB_WriteReg_addr = 5'($urandom_range(0, 3));
        WB_Data          = $urandom;
    endtask

    task automatic randomize_idex();
        ReadReg_addr13 = 5'($urandom_range(0, 3));
        ReadReg_addr23 = 5'($urandom_range(0, 3));
        WriteReg_addr3 = 5'($urandom_range(0, 3));
        Imm3 = $urandom; ReadData13 = $urandom; ReadData23 = $urandom;
        if ($urandom_range(0, 3) == 0) ReadData23 = ReadData13;
        Next_PC3 = $urandom;
        JtoPC3 = ($urandom_range(0, 7) == 0);
        Branch3 = ($urandom_range(0, 3) == 0);
        RegWrite3 = 1'($urandom_range(0, 1)); ALUSrc3 = 1'($urandom_range(0, 1));
        MemWrite3 = 1'($urandom_range(0, 1)); MemRead3 = 1'($urandom_range(0, 1));
        MemtoReg3 = 1'($urandom_range(0, 1));
        ALUOp3 = 4'($urandom_range(0, 15));
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_prod);
        set_alu(4'd11, 5'd0, a, 5'd0, b, 5'd7);
        stall_seen = 0;
        for (int i = 0; i < 33; i++) run_cycle();
        check_eq("mul_stall_cycles", stall_seen, 32);
        check_eq("mul_product", ALUResult4, exp_prod);
        check_eq("mul_dest", WriteReg_addr4, 5'd7);
        set_nop();
        run_cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        RST = 1'b1;
        set_nop();
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_alu", ALUResult4, 0);
        check_eq("rst_wd", WriteData4, 0);
        check_eq("rst_ctrl", {WriteReg_addr4, RegWrite4, MemWrite4, MemRead4, MemtoReg4}, 0);
        check_eq("rst_stall", Stall_Out, 0);
        RST = 1'b0;

        // plain ADD
        set_alu(4'd0, 5'd0, 32'd5, 5'd0, 32'd7, 5'd1);
        run_cycle();
        check_eq("add_5_7", ALUResult4, 32'd12);
        check_eq("add_regwrite", RegWrite4, 1);

        // forwarding priority: MEM over WB, then WB alone, r0 never forwarded
        set_alu(4'd0, 5'd0, 32'd60, 5'd0, 32'd40, 5'd3);
        WB_RegWrite = 1; WB_WriteReg_addr = 5'd3; WB_Data = 32'd55;
        run_cycle();
        set_alu(4'd1, 5'd3, 32'd999, 5'd0, 32'd0, 5'd5);
        WB_RegWrite = 1; WB_WriteReg_addr = 5'd3; WB_Data = 32'd55;
        run_cycle();
        check_eq("fwd_mem_wins", ALUResult4, 32'd100);
        set_alu(4'd1, 5'd3, 32'd999, 5'd0, 32'd0, 5'd6);
        WB_RegWrite = 1; WB_WriteReg_addr = 5'd3; WB_Data = 32'd55;
        run_cycle();
        check_eq("fwd_wb_only", ALUResult4, 32'd55);
        set_alu(4'd0, 5'd0, 32'd77, 5'd0, 32'd0, 5'd0);
        RegWrite3 = 1;
        run_cycle();
        set_alu(4'd0, 5'd0, 32'd1, 5'd0, 32'd2, 5'd1);
        WB_RegWrite = 1; WB_WriteReg_addr = 5'd0; WB_Data = 32'd500;
        run_cycle();
        check_eq("fwd_r0_never", ALUResult4, 32'd3);

        // branch / jump
        set_alu(4'd1, 5'd0, 32'd9, 5'd0, 32'd9, 5'd0);
        Branch3 = 1; Next_PC3 = 32'h40; Imm3 = 32'd3;
        #1; check_eq("beq_taken", PC_Redirect, 1);
        check_eq("beq_target", Redirect_PC, 32'h4C);
        run_cycle();
        ReadData23 = 32'd8;
        #1; check_eq("beq_not_taken", PC_Redirect, 0);
        run_cycle();
        set_nop();
        JtoPC3 = 1; Branch3 = 1; Next_PC3 = 32'hA000_0040; Imm3 = 32'h10;
        #1; check_eq("jump_target", Redirect_PC, 32'hA000_0040);
        run_cycle();

        // ALU corner ops
        set_alu(4'd9, 5'd0, 32'h8000_0000, 5'd0, 32'd4, 5'd1);
        run_cycle();
        check_eq("sra", ALUResult4, 32'hF800_0000);
        set_alu(4'd6, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd1, 5'd1);
        run_cycle();
        check_eq("slt_signed", ALUResult4, 32'd1);
        set_alu(4'd10, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1);
        ALUSrc3 = 1; Imm3 = 32'h1234;
        run_cycle();
        check_eq("lui", ALUResult4, 32'h1234_0000);

        // multiplies, including back-to-back
        run_mul(32'd6, 32'd7, 32'd42);
        run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        set_alu(4'd11, 5'd0, 32'd3, 5'd0, 32'd5, 5'd2);
        for (int i = 0; i < 66; i++) run_cycle();
        check_eq("mul_b2b", ALUResult4, 32'd15);

        // reset during iteration 10 of a multiply
        set_alu(4'd11, 5'd0, 32'd6, 5'd0, 32'd7, 5'd4);
        for (int i = 0; i < 11; i++) run_cycle();
        #2 RST = 1'b1;
        #1;
        check_eq("rst_mid_alu", ALUResult4, 0);
        check_eq("rst_mid_ctrl", {WriteReg_addr4, RegWrite4, MemWrite4, MemRead4, MemtoReg4}, 0);
        check_eq("rst_mid_state", dut.u_mul.fsm_state, IDLE);
        set_nop();
        @(posedge CLK);
        #1 RST = 1'b0;
        model_reset();
        #1;
        check_eq("rst_rel_stall", Stall_Out, 0);
        check_eq("rst_rel_state", dut.u_mul.fsm_state, IDLE);
        @(posedge CLK);
        #1;

        // randomized traffic; ID/EX held while a multiply is in flight
        for (int i = 0; i < 400; i++) begin
            if (mul_left == 0) randomize_idex();
            randomize_wb();
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
